// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RISC-V main controller.
package multicycle_pkg;

   // Controller states. Encoding 4'd15 is unused and recovers to StFetch.
   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecR   = 4'd6,
      StExecI   = 4'd7,
      StAluWb   = 4'd8,
      StBeq     = 4'd9,
      StJalr    = 4'd10,
      StJump    = 4'd11,
      StLui     = 4'd12,
      StAuipc   = 4'd13,
      StIllegal = 4'd14
   } state_e;

   // Supported major opcodes (instr[6:0]).
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   typedef enum logic [1:0] {
      AluAdd    = 2'b00,
      AluSub    = 2'b01,
      AluRFunct = 2'b10,
      AluIFunct = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ResAluOut    = 2'b00,
      ResMemData   = 2'b01,
      ResAluResult = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      SrcAPc    = 2'b00,
      SrcAOldPc = 2'b01,
      SrcARs1   = 2'b10,
      SrcAZero  = 2'b11
   } alu_src_a_e;

   typedef enum logic [1:0] {
      SrcBRs2  = 2'b00,
      SrcBImm  = 2'b01,
      SrcBFour = 2'b10
   } alu_src_b_e;

   // Full set of datapath controls produced for one cycle.
   typedef struct packed {
      logic        mem_req;
      logic        mem_we;
      logic        adr_src;
      logic        ir_write;
      logic        pc_write;
      logic        branch;
      logic        reg_write;
      result_src_e result_src;
      alu_src_a_e  alu_src_a;
      alu_src_b_e  alu_src_b;
      alu_op_e     alu_op;
      logic        illegal;
   } ctrl_t;

   // State that follows DECODE for a given opcode.
   function automatic state_e decode_next(input logic [6:0] opcode);
      case (opcode)
         OpLoad, OpStore: return StMemAdr;
         OpRType:         return StExecR;
         OpIType:         return StExecI;
         OpBranch:        return StBeq;
         OpJal:           return StJump;
         OpJalr:          return StJalr;
         OpLui:           return StLui;
         OpAuipc:         return StAuipc;
         default:         return StIllegal;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller side uses
// the master modport; the datapath (or a bench) uses the slave modport.
interface multicycle_control_if #(
   parameter int unsigned CNT_W = 32
);

   logic [6:0]       opcode;
   logic             mem_ready;
   logic             mem_req;
   logic             mem_we;
   logic             adr_src;
   logic             ir_write;
   logic             pc_write;
   logic             branch;
   logic             reg_write;
   logic [1:0]       result_src;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic             illegal;
   logic [CNT_W-1:0] instret;

   modport master (
      input  opcode,
      input  mem_ready,
      output mem_req,
      output mem_we,
      output adr_src,
      output ir_write,
      output pc_write,
      output branch,
      output reg_write,
      output result_src,
      output alu_src_a,
      output alu_src_b,
      output alu_op,
      output illegal,
      output instret
   );

   modport slave (
      output opcode,
      output mem_ready,
      input  mem_req,
      input  mem_we,
      input  adr_src,
      input  ir_write,
      input  pc_write,
      input  branch,
      input  reg_write,
      input  result_src,
      input  alu_src_a,
      input  alu_src_b,
      input  alu_op,
      input  illegal,
      input  instret
   );

endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Moore output decoder: datapath controls from the current state. Only the
// FETCH-cycle IR/PC write strobes depend on mem_ready.
module multicycle_ctrl_outdec
   import multicycle_pkg::*;
(
   input  state_e i_state,
   input  logic   i_mem_ready,
   output ctrl_t  o_ctrl
);

   // Per-state control decode; everything not set below stays 0.
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         StFetch: begin
            o_ctrl.mem_req    = 1'b1;
            o_ctrl.ir_write   = i_mem_ready;
            o_ctrl.pc_write   = i_mem_ready;
            o_ctrl.alu_src_a  = SrcAPc;
            o_ctrl.alu_src_b  = SrcBFour;
            o_ctrl.alu_op     = AluAdd;
            o_ctrl.result_src = ResAluResult;
         end
         StDecode: begin
            // OldPC + imm precomputes the branch/jal target
            o_ctrl.alu_src_a = SrcAOldPc;
            o_ctrl.alu_src_b = SrcBImm;
            o_ctrl.alu_op    = AluAdd;
         end
         StMemAdr: begin
            o_ctrl.alu_src_a = SrcARs1;
            o_ctrl.alu_src_b = SrcBImm;
            o_ctrl.alu_op    = AluAdd;
         end
         StMemRd: begin
            o_ctrl.mem_req = 1'b1;
            o_ctrl.adr_src = 1'b1;
         end
         StMemWb: begin
            o_ctrl.result_src = ResMemData;
            o_ctrl.reg_write  = 1'b1;
         end
         StMemWr: begin
            o_ctrl.mem_req = 1'b1;
            o_ctrl.mem_we  = 1'b1;
            o_ctrl.adr_src = 1'b1;
         end
         StExecR: begin
            o_ctrl.alu_src_a = SrcARs1;
            o_ctrl.alu_src_b = SrcBRs2;
            o_ctrl.alu_op    = AluRFunct;
         end
         StExecI: begin
            o_ctrl.alu_src_a = SrcARs1;
            o_ctrl.alu_src_b = SrcBImm;
            o_ctrl.alu_op    = AluIFunct;
         end
         StAluWb: begin
            o_ctrl.result_src = ResAluOut;
            o_ctrl.reg_write  = 1'b1;
         end
         StBeq: begin
            // Subtract to compare; target from DECODE is on ALUOut
            o_ctrl.alu_src_a  = SrcARs1;
            o_ctrl.alu_src_b  = SrcBRs2;
            o_ctrl.alu_op     = AluSub;
            o_ctrl.result_src = ResAluOut;
            o_ctrl.branch     = 1'b1;
         end
         StJalr: begin
            o_ctrl.alu_src_a = SrcARs1;
            o_ctrl.alu_src_b = SrcBImm;
            o_ctrl.alu_op    = AluAdd;
         end
         StJump: begin
            // PC <= target on ALUOut while ALU forms the link value OldPC + 4
            o_ctrl.alu_src_a  = SrcAOldPc;
            o_ctrl.alu_src_b  = SrcBFour;
            o_ctrl.alu_op     = AluAdd;
            o_ctrl.result_src = ResAluOut;
            o_ctrl.pc_write   = 1'b1;
         end
         StLui: begin
            o_ctrl.alu_src_a = SrcAZero;
            o_ctrl.alu_src_b = SrcBImm;
            o_ctrl.alu_op    = AluAdd;
         end
         StAuipc: begin
            o_ctrl.alu_src_a = SrcAOldPc;
            o_ctrl.alu_src_b = SrcBImm;
            o_ctrl.alu_op    = AluAdd;
         end
         StIllegal: begin
            o_ctrl.illegal = 1'b1;
         end
         default: begin
            o_ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main controller of the multi-cycle RISC-V core: state sequencing,
// memory handshake and retired-instruction counter.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_control_if.master ctrl_bus
);

   state_e           r_state;
   state_e           w_next_state;
   ctrl_t            w_ctrl;
   logic             w_retire;
   logic [CNT_W-1:0] r_instret;

   // State register; reset drops any pending memory access immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StFetch;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state sequencing; memory states hold until mem_ready.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         StFetch:   if (ctrl_bus.mem_ready) w_next_state = StDecode;
         StDecode:  w_next_state = decode_next(ctrl_bus.opcode);
         StMemAdr:  w_next_state = (ctrl_bus.opcode == OpStore) ? StMemWr : StMemRd;
         StMemRd:   if (ctrl_bus.mem_ready) w_next_state = StMemWb;
         StMemWb:   w_next_state = StFetch;
         StMemWr:   if (ctrl_bus.mem_ready) w_next_state = StFetch;
         StExecR:   w_next_state = StAluWb;
         StExecI:   w_next_state = StAluWb;
         StAluWb:   w_next_state = StFetch;
         StBeq:     w_next_state = StFetch;
         StJalr:    w_next_state = StJump;
         StJump:    w_next_state = StAluWb;
         StLui:     w_next_state = StAluWb;
         StAuipc:   w_next_state = StAluWb;
         StIllegal: w_next_state = StFetch;
         default:   w_next_state = StFetch;
      endcase
   end

   // Final cycle of every legal instruction; ILLEGAL never retires.
   always_comb begin
      w_retire = (r_state == StMemWb) || (r_state == StAluWb) || (r_state == StBeq) ||
                 ((r_state == StMemWr) && ctrl_bus.mem_ready);
   end

   // Retired-instruction counter, wraps modulo 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instret <= '0;
      end else if (w_retire) begin
         r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   multicycle_ctrl_outdec u_outdec (
      .i_state     (r_state),
      .i_mem_ready (ctrl_bus.mem_ready),
      .o_ctrl      (w_ctrl)
   );

   assign ctrl_bus.mem_req    = w_ctrl.mem_req;
   assign ctrl_bus.mem_we     = w_ctrl.mem_we;
   assign ctrl_bus.adr_src    = w_ctrl.adr_src;
   assign ctrl_bus.ir_write   = w_ctrl.ir_write;
   assign ctrl_bus.pc_write   = w_ctrl.pc_write;
   assign ctrl_bus.branch     = w_ctrl.branch;
   assign ctrl_bus.reg_write  = w_ctrl.reg_write;
   assign ctrl_bus.result_src = w_ctrl.result_src;
   assign ctrl_bus.alu_src_a  = w_ctrl.alu_src_a;
   assign ctrl_bus.alu_src_b  = w_ctrl.alu_src_b;
   assign ctrl_bus.alu_op     = w_ctrl.alu_op;
   assign ctrl_bus.illegal    = w_ctrl.illegal;
   assign ctrl_bus.instret    = r_instret;

endmodule
